// File: rtl/mcb_cmd_arbiter.sv
// rtl/mcb_cmd_arbiter.sv - round-robin write/read command scheduler for one LPDDR controller port
// Gates each client on data-FIFO occupancy and keeps a wrapping byte pointer per client.
module mcb_cmd_arbiter #(
  parameter logic [29:0] WR_BASE    = 30'h0000000,
  parameter logic [29:0] WR_LIMIT   = 30'h0001000,
  parameter logic [29:0] RD_BASE    = 30'h0000000,
  parameter logic [29:0] RD_LIMIT   = 30'h0001000,
  parameter int          FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_req,
  input  logic [5:0]  wr_req_bl,
  output logic        wr_grant,
  input  logic        rd_req,
  input  logic [5:0]  rd_req_bl,
  output logic        rd_grant,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  input  logic        cmd_full,
  input  logic [6:0]  wr_count,
  input  logic [6:0]  rd_count,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t      state, state_next;
  logic        last;
  logic        win_rd;
  logic [29:0] wr_ptr, rd_ptr;
  logic        wr_ok, rd_ok, pick_rd;
  logic [7:0]  wr_need, rd_need, rd_room;
  logic [30:0] adv_sum, adv_limit;
  logic [29:0] adv_next;

  // 8-bit compares so a full 64-word FIFO is not mistaken for empty
  assign wr_need = {2'b00, wr_req_bl} + 8'd1;
  assign rd_need = {2'b00, rd_req_bl} + 8'd1;
  assign rd_room = 8'(FIFO_DEPTH) - {1'b0, rd_count};

  assign wr_ok   = wr_req && !cmd_full && ({1'b0, wr_count} >= wr_need);
  assign rd_ok   = rd_req && !cmd_full && (rd_room >= rd_need);
  // last = 1 means read was granted last, so write wins a tie
  assign pick_rd = rd_ok && (!wr_ok || !last);

  assign adv_sum   = {1'b0, cmd_byte_addr} + (({25'd0, cmd_bl} + 31'd1) << 2);
  assign adv_limit = {1'b0, (win_rd ? RD_LIMIT : WR_LIMIT)};
  assign adv_next  = (adv_sum >= adv_limit) ? (win_rd ? RD_BASE : WR_BASE) : adv_sum[29:0];

  assign cmd_en   = (state == ISSUE);
  assign wr_grant = cmd_en && !win_rd;
  assign rd_grant = cmd_en && win_rd;
  assign busy     = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (wr_ok || rd_ok) state_next = ISSUE;
      ISSUE:   state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last          <= 1'b1;
      win_rd        <= 1'b0;
      wr_ptr        <= WR_BASE;
      rd_ptr        <= RD_BASE;
      cmd_instr     <= 3'b000;
      cmd_bl        <= 6'd0;
      cmd_byte_addr <= 30'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == ISSUE) begin
        win_rd        <= pick_rd;
        cmd_instr     <= pick_rd ? 3'b001 : 3'b000;
        cmd_bl        <= pick_rd ? rd_req_bl : wr_req_bl;
        cmd_byte_addr <= pick_rd ? rd_ptr : wr_ptr;
      end
      if (state == ISSUE) begin
        last <= win_rd;
        if (win_rd) rd_ptr <= adv_next;
        else        wr_ptr <= adv_next;
      end
    end
  end

endmodule
